// File: rtl/sobel_window_feeder_pkg.sv
// sobel_pkg: shared feeder state type, pixel width and 3x3 window index constants.
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_SIZE = 9;

  // Window positions: P0-P2 top (oldest) row, P6-P8 bottom (newest) row, left to right
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/sobel_window_feeder_if.sv
// sobel_window_feeder_if: pixel stream, edge-core handshake and result signals of the feeder.
// master = the feeder itself, slave = its environment (pixel source, edge core, consumer).
interface sobel_window_feeder_if;
  import sobel_pkg::*;

  logic             i_sof;
  logic             i_pix_valid;
  logic [PIX_W-1:0] i_pix;
  logic             o_pix_ready;
  logic             o_gradient_start;
  logic [PIX_W-1:0] o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8;
  logic             i_gradient_data_ready;
  logic [PIX_W-1:0] i_processed_sum;
  logic             o_result_valid;
  logic [PIX_W-1:0] o_result;
  logic             o_frame_done;

  modport master (
    input  i_sof, i_pix_valid, i_pix, i_gradient_data_ready, i_processed_sum,
    output o_pix_ready, o_gradient_start,
    output o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8,
    output o_result_valid, o_result, o_frame_done
  );

  modport slave (
    output i_sof, i_pix_valid, i_pix, i_gradient_data_ready, i_processed_sum,
    input  o_pix_ready, o_gradient_start,
    input  o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8,
    input  o_result_valid, o_result, o_frame_done
  );

endinterface

// File: rtl/sobel_window_feeder_line_buffer.sv
// sobel_line_buffer: DEPTH-deep pixel delay line; o_dout is the pixel shifted in DEPTH shifts ago.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_shift,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_dout
);

  logic [PIX_W-1:0] r_taps [DEPTH];

  // Shift one pixel in at tap 0 on every enable; the oldest pixel sits at the last tap
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else if (i_shift) begin
      r_taps[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  assign o_dout = r_taps[DEPTH-1];

endmodule

// File: rtl/sobel_window_feeder.sv
// sobel_window_feeder: builds 3x3 windows from a raster pixel stream, hands each complete
// window to the edge core and re-emits the core's result as a one-cycle pulse.
// Optional macro SOBEL_ZERO_BORDER_EN: border pixels emit a 0 result instead of nothing.
module sobel_window_feeder
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sobel_window_feeder_if.master io_bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  feeder_state_t    r_state, w_next;
  logic [CW-1:0]    r_col, w_col;
  logic [RW-1:0]    r_row, w_row;
  logic             r_frameDone;
  logic [PIX_W-1:0] r_result;
  logic [PIX_W-1:0] r_win [WIN_SIZE];
  logic [PIX_W-1:0] w_lb0Out, w_lb1Out;
  logic             w_accept, w_winValid, w_lastCol, w_lastRow;

  // A start-of-frame pixel is positioned as (0,0) regardless of the running counters
  assign w_accept   = io_bus.i_pix_valid && (r_state == IDLE);
  assign w_row      = io_bus.i_sof ? '0 : r_row;
  assign w_col      = io_bus.i_sof ? '0 : r_col;
  assign w_winValid = (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_lastCol  = (w_col == CW'(IMG_WIDTH - 1));
  assign w_lastRow  = (w_row == RW'(IMG_HEIGHT - 1));

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_shift(w_accept),
    .i_din  (io_bus.i_pix),
    .o_dout (w_lb1Out)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_shift(w_accept),
    .i_din  (w_lb1Out),
    .o_dout (w_lb0Out)
  );

  // Raster position tracking and the end-of-frame pulse; i_sof alone also clears the position
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_accept) begin
        if (w_lastCol) begin
          r_col <= '0;
          if (w_lastRow) begin
            r_row       <= '0;
            r_frameDone <= 1'b1;
          end else begin
            r_row <= w_row + RW'(1);
          end
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end else if (io_bus.i_sof) begin
        r_row <= '0;
        r_col <= '0;
      end
    end
  end

  // Slide the window left and bring in the new right column from the line buffers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < WIN_SIZE; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_win[P0] <= r_win[P1];
      r_win[P1] <= r_win[P2];
      r_win[P2] <= w_lb0Out;
      r_win[P3] <= r_win[P4];
      r_win[P4] <= r_win[P5];
      r_win[P5] <= w_lb1Out;
      r_win[P6] <= r_win[P7];
      r_win[P7] <= r_win[P8];
      r_win[P8] <= io_bus.i_pix;
    end
  end

  // Capture the edge core's sum (or a zero for border pixels when that option is built in)
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_result <= '0;
    end else if ((r_state == WAIT) && io_bus.i_gradient_data_ready) begin
      r_result <= io_bus.i_processed_sum;
`ifdef SOBEL_ZERO_BORDER_EN
    end else if (w_accept && !w_winValid) begin
      r_result <= '0;
`endif
    end
  end

  // Feeder state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; ready from the core is only meaningful while waiting for it
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_winValid) w_next = START;
`ifdef SOBEL_ZERO_BORDER_EN
          else            w_next = EMIT;
`endif
        end
      end
      START:   w_next = WAIT;
      WAIT:    if (io_bus.i_gradient_data_ready) w_next = EMIT;
      EMIT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs; ready is also held low while reset is asserted so every output reads 0
  always_comb begin
    io_bus.o_pix_ready      = n_rst && (r_state == IDLE);
    io_bus.o_gradient_start = (r_state == START);
    io_bus.o_result_valid   = (r_state == EMIT);
  end

  assign io_bus.o_result     = r_result;
  assign io_bus.o_frame_done = r_frameDone;
  assign io_bus.o_p0         = r_win[P0];
  assign io_bus.o_p1         = r_win[P1];
  assign io_bus.o_p2         = r_win[P2];
  assign io_bus.o_p3         = r_win[P3];
  assign io_bus.o_p4         = r_win[P4];
  assign io_bus.o_p5         = r_win[P5];
  assign io_bus.o_p6         = r_win[P6];
  assign io_bus.o_p7         = r_win[P7];
  assign io_bus.o_p8         = r_win[P8];

endmodule

// File: tb/tb_sobel_window_feeder.sv
// tb_sobel_window_feeder: directed frames on a 4x4 image against a behavioural Sobel edge core.
// Builds with or without SOBEL_ZERO_BORDER_EN; expected result lists follow the build option.
module tb_sobel_window_feeder;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  sobel_window_feeder_if bus ();

  sobel_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Sobel magnitude |Gx|+|Gy| saturated to 8 bits
  function automatic bit [7:0] sobel(input logic [7:0] w[9]);
    int gx, gy, m;
    gx = (int'(w[2]) + 2*int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2*int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[1]) + int'(w[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  // Behavioural edge core: latches the window on start, answers 20 cycles later
  bit         coreBusy;
  bit         coreReady;
  bit  [7:0]  coreSum;
  int         coreCnt;
  logic [7:0] coreWin [9];

  assign bus.i_gradient_data_ready = coreReady;
  assign bus.i_processed_sum       = coreSum;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coreBusy  <= 1'b0;
      coreReady <= 1'b0;
      coreSum   <= 8'd0;
      coreCnt   <= 0;
    end else begin
      coreReady <= 1'b0;
      if (bus.o_gradient_start) begin
        coreBusy   <= 1'b1;
        coreCnt    <= 19;
        coreWin[0] <= bus.o_p0;
        coreWin[1] <= bus.o_p1;
        coreWin[2] <= bus.o_p2;
        coreWin[3] <= bus.o_p3;
        coreWin[4] <= bus.o_p4;
        coreWin[5] <= bus.o_p5;
        coreWin[6] <= bus.o_p6;
        coreWin[7] <= bus.o_p7;
        coreWin[8] <= bus.o_p8;
      end else if (coreBusy) begin
        if (coreCnt == 0) begin
          coreBusy  <= 1'b0;
          coreReady <= 1'b1;
          coreSum   <= sobel(coreWin);
        end else begin
          coreCnt <= coreCnt - 1;
        end
      end
    end
  end

  // Output monitor sampled on the falling edge
  logic [71:0] obsWin, coreFlat;
  logic [71:0] winQ [$];
  int          resQ [$];
  int          startCount = 0;
  int          doneCount  = 0;
  int          doneAt     = -1;
  int          stableErr  = 0;
  int          readyErr   = 0;
  int          acceptCount = 0;

  assign obsWin   = {bus.o_p0, bus.o_p1, bus.o_p2, bus.o_p3, bus.o_p4,
                     bus.o_p5, bus.o_p6, bus.o_p7, bus.o_p8};
  assign coreFlat = {coreWin[0], coreWin[1], coreWin[2], coreWin[3], coreWin[4],
                     coreWin[5], coreWin[6], coreWin[7], coreWin[8]};

  always @(negedge clk) begin
    if (bus.o_result_valid) resQ.push_back(int'(bus.o_result));
    if (bus.o_gradient_start) begin
      startCount++;
      winQ.push_back(obsWin);
    end
    if (bus.o_frame_done) begin
      doneCount++;
      doneAt = acceptCount;
    end
    if (coreBusy) begin
      if (obsWin !== coreFlat) stableErr++;
      if (bus.o_pix_ready !== 1'b0) readyErr++;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one pixel (valid stays high) and wait, bounded, until it is accepted; called at negedge+1
  task automatic applyStimulus(input logic [7:0] pix, input bit sof);
    int budget;
    budget = 0;
    bus.i_pix       = pix;
    bus.i_sof       = sof;
    bus.i_pix_valid = 1'b1;
    while (!bus.o_pix_ready && budget < 100) begin
      @(negedge clk); #1;
      budget++;
    end
    checkOutput("pixel accepted", int'(bus.o_pix_ready), 1);
    if (bus.o_pix_ready) acceptCount++;
    @(negedge clk); #1;
    bus.i_sof = 1'b0;
  endtask

  task automatic waitResults(input int base, input int n);
    int budget;
    budget = 0;
    while ((resQ.size() - base) < n && budget < 600) begin
      @(negedge clk); #1;
      budget++;
    end
    repeat (30) @(negedge clk);
    #1;
  endtask

  int winBase;

  task automatic runFrame(input string tag, input logic [7:0] frm[16], input int win[4], input bit sof);
    int resBase, startBase, doneBase, accBase, wi;
    int expList [$];
    resBase   = resQ.size();
    startBase = startCount;
    doneBase  = doneCount;
    accBase   = acceptCount;
    winBase   = winQ.size();
    for (int i = 0; i < 16; i++) applyStimulus(frm[i], sof && (i == 0));
    bus.i_pix_valid = 1'b0;
    wi = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i / W) >= 2 && (i % W) >= 2) begin
        expList.push_back(win[wi]);
        wi++;
      end
`ifdef SOBEL_ZERO_BORDER_EN
      else expList.push_back(0);
`endif
    end
    waitResults(resBase, expList.size());
    checkOutput({tag, " result count"}, resQ.size() - resBase, expList.size());
    for (int i = 0; i < expList.size(); i++)
      if (resBase + i < resQ.size())
        checkOutput($sformatf("%s result%0d", tag, i), resQ[resBase + i], expList[i]);
    checkOutput({tag, " start pulses"}, startCount - startBase, 4);
    checkOutput({tag, " frame_done pulses"}, doneCount - doneBase, 1);
    checkOutput({tag, " frame_done after accept"}, doneAt - accBase, 16);
    checkOutput({tag, " window stable in WAIT"}, stableErr, 0);
    checkOutput({tag, " ready low while busy"}, readyErr, 0);
  endtask

  logic [7:0] frmUniform [16];
  logic [7:0] frmVert    [16];
  logic [7:0] frmBright  [16];
  logic [7:0] frmRamp    [16];
  int         winZero    [4];
  int         win255     [4];
  int         winBright  [4];
  int         winRamp    [4];

  initial begin
    int sb, rb, k;
    logic [71:0] w0;

    for (int i = 0; i < 16; i++) begin
      frmUniform[i] = 8'd50;
      frmVert[i]    = ((i % W) >= 2) ? 8'd255 : 8'd0;
      frmBright[i]  = (i == 10) ? 8'd60 : 8'd0;
      frmRamp[i]    = 8'((i % W) + 5 * (i / W));
    end
    // Hand-computed window results in acceptance order (2,2),(2,3),(3,2),(3,3)
    winZero   = '{0, 0, 0, 0};
    win255    = '{255, 255, 255, 255};
    winBright = '{120, 120, 120, 0};
    winRamp   = '{48, 48, 48, 48};

    bus.i_sof       = 1'b0;
    bus.i_pix_valid = 1'b0;
    bus.i_pix       = 8'd0;
    n_rst           = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset pix_ready", int'(bus.o_pix_ready), 0);
    checkOutput("reset gradient_start", int'(bus.o_gradient_start), 0);
    checkOutput("reset result_valid", int'(bus.o_result_valid), 0);
    checkOutput("reset window", int'(obsWin != 72'd0), 0);
    n_rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("idle pix_ready", int'(bus.o_pix_ready), 1);

    $display("[TB] uniform frame");
    runFrame("uniform", frmUniform, winZero, 1'b1);

    $display("[TB] single bright pixel frame");
    runFrame("bright", frmBright, winBright, 1'b1);

    $display("[TB] vertical edge frame");
    runFrame("vertical", frmVert, win255, 1'b1);
    w0 = (winQ.size() > winBase) ? winQ[winBase] : 72'd0;
    checkOutput("vertical first window top",    int'(w0[71:48]), int'({8'd0, 8'd0, 8'd255}));
    checkOutput("vertical first window middle", int'(w0[47:24]), int'({8'd0, 8'd0, 8'd255}));
    checkOutput("vertical first window bottom", int'(w0[23:0]),  int'({8'd0, 8'd0, 8'd255}));

    $display("[TB] reset during WAIT");
    sb = startCount;
    for (int i = 0; i < 11; i++) applyStimulus(frmBright[i], i == 0);
    bus.i_pix_valid = 1'b0;
    k = 0;
    while (startCount == sb && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("reset test start seen", startCount - sb, 1);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("wait p8", int'(bus.o_p8), 60);
    checkOutput("wait pix_ready", int'(bus.o_pix_ready), 0);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("midreset p8", int'(bus.o_p8), 0);
    checkOutput("midreset pix_ready", int'(bus.o_pix_ready), 0);
    checkOutput("midreset result_valid", int'(bus.o_result_valid), 0);
    checkOutput("midreset result", int'(bus.o_result), 0);
    checkOutput("midreset frame_done", int'(bus.o_frame_done), 0);
    @(negedge clk); #1;
    n_rst = 1'b1;
    rb = resQ.size();
    repeat (40) @(negedge clk);
    #1;
    checkOutput("no result after reset", resQ.size() - rb, 0);
    runFrame("ramp after reset", frmRamp, winRamp, 1'b1);

    $display("[TB] i_sof mid-frame");
    for (int i = 0; i < 10; i++) applyStimulus(frmUniform[i], i == 0);
    bus.i_pix_valid = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    runFrame("sof restart", frmVert, win255, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
